// File: rtl/spi_burst_ram_pkg.sv
// spi_burst_ram shared types.
// Command encodings and the frame FSM state enum.
package spi_burst_ram_pkg;

    typedef enum logic [1:0] {
        CMD_SET_WADDR = 2'b00,
        CMD_WRITE     = 2'b01,
        CMD_SET_RADDR = 2'b10,
        CMD_READ      = 2'b11
    } cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        WDATA,
        RTURN,
        RDATA
    } state_e;

endpackage

// File: rtl/spi_burst_ram_mem.sv
// spi_burst_ram word store.
// Single port, synchronous read/write, one-cycle read latency, no reset.
module spi_burst_ram_mem #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) mem[addr] <= wdata;
            else    rdata     <= mem[addr];
        end
    end

endmodule

// File: rtl/spi_burst_ram.sv
// spi_burst_ram: clk-sampled SPI-style slave in front of a burst RAM.
// Frame = 2-bit command, then an address field or a stream of data words.
module spi_burst_ram
    import spi_burst_ram_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256
) (
    input  logic clk,
    input  logic rst,
    input  logic SS_n,
    input  logic MOSI,
    output logic MISO,
    output logic frame_err
);

    localparam int MAXW  = (DATA_W > ADDR_W) ? DATA_W : ADDR_W;
    localparam int CNT_W = (MAXW > 1) ? $clog2(MAXW) : 1;
    localparam logic [CNT_W-1:0] D_LAST = CNT_W'(DATA_W - 1);
    localparam logic [CNT_W-1:0] A_LAST = CNT_W'(ADDR_W - 1);

    if (MEM_DEPTH < 2 || MEM_DEPTH > (1 << ADDR_W) || DATA_W < 2)
    begin : g_bad_param
        $error("spi_burst_ram: illegal MEM_DEPTH/ADDR_W/DATA_W");
    end

    function automatic logic [ADDR_W-1:0] ptr_inc(
        input logic [ADDR_W-1:0] p
    );
        return (p == ADDR_W'(MEM_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    function automatic logic [ADDR_W-1:0] ptr_mod(
        input logic [ADDR_W-1:0] v
    );
        return ADDR_W'(32'(v) % MEM_DEPTH);
    endfunction

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q;
    logic              cmd_hi_q;
    logic              addr_rd_q;
    logic              addr_done_q;
    logic              armed_q;
    logic [ADDR_W-1:0] asr_q;
    logic [DATA_W-1:0] dsr_q;
    logic [ADDR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic              miso_q, ferr_q;

    logic              ram_en, ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] w_word;
    logic [ADDR_W-1:0] a_word;
    logic              d_last, a_last;

    assign w_word = DATA_W'({dsr_q, MOSI});
    assign a_word = ADDR_W'({asr_q, MOSI});
    assign d_last = (cnt_q == D_LAST);
    assign a_last = (cnt_q == A_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = rd_ptr_q;
        if (SS_n) begin
            state_d = IDLE;
        end else begin
            unique case (state_q)
                IDLE: if (armed_q) state_d = CMD;
                CMD: begin
                    unique case (cmd_e'({cmd_hi_q, MOSI}))
                        CMD_WRITE: state_d = WDATA;
                        CMD_READ:  state_d = RTURN;
                        default:   state_d = ADDR;
                    endcase
                end
                ADDR: state_d = ADDR;
                WDATA: begin
                    if (d_last) begin
                        ram_en   = 1'b1;
                        ram_we   = 1'b1;
                        ram_addr = wr_ptr_q;
                    end
                end
                RTURN: begin
                    state_d = RDATA;
                    ram_en  = 1'b1;
                end
                // rd_ptr already points past the word being shifted out
                RDATA: if (d_last) ram_en = 1'b1;
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q       <= '0;
            cmd_hi_q    <= 1'b0;
            addr_rd_q   <= 1'b0;
            addr_done_q <= 1'b0;
            armed_q     <= 1'b0;
            asr_q       <= '0;
            dsr_q       <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            miso_q      <= 1'b0;
            ferr_q      <= 1'b0;
        end else begin
            ferr_q <= 1'b0;
            if (SS_n) begin
                armed_q <= 1'b1;
                cnt_q   <= '0;
                miso_q  <= 1'b0;
                if ((state_q == ADDR && !addr_done_q && cnt_q != '0) ||
                    (state_q == WDATA && cnt_q != '0))
                    ferr_q <= 1'b1;
            end else begin
                unique case (state_q)
                    IDLE: begin
                        cmd_hi_q <= MOSI;
                        cnt_q    <= '0;
                    end
                    CMD: begin
                        addr_rd_q   <= cmd_hi_q;
                        addr_done_q <= 1'b0;
                        cnt_q       <= '0;
                    end
                    ADDR: begin
                        if (!addr_done_q) begin
                            asr_q <= a_word;
                            if (a_last) begin
                                addr_done_q <= 1'b1;
                                cnt_q       <= '0;
                                if (addr_rd_q) rd_ptr_q <= ptr_mod(a_word);
                                else           wr_ptr_q <= ptr_mod(a_word);
                            end else begin
                                cnt_q <= cnt_q + 1'b1;
                            end
                        end
                    end
                    WDATA: begin
                        dsr_q <= w_word;
                        if (d_last) begin
                            wr_ptr_q <= ptr_inc(wr_ptr_q);
                            cnt_q    <= '0;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    RTURN: begin
                        miso_q <= 1'b0;
                        cnt_q  <= '0;
                    end
                    RDATA: begin
                        if (cnt_q == '0) begin
                            miso_q   <= ram_rdata[DATA_W-1];
                            dsr_q    <= ram_rdata << 1;
                            rd_ptr_q <= ptr_inc(rd_ptr_q);
                        end else begin
                            miso_q <= dsr_q[DATA_W-1];
                            dsr_q  <= dsr_q << 1;
                        end
                        cnt_q <= d_last ? '0 : cnt_q + 1'b1;
                    end
                    default: cnt_q <= '0;
                endcase
            end
        end
    end

    spi_burst_ram_mem #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .MEM_DEPTH (MEM_DEPTH)
    ) u_mem (
        .clk   (clk),
        .en    (ram_en),
        .we    (ram_we),
        .addr  (ram_addr),
        .wdata (w_word),
        .rdata (ram_rdata)
    );

    assign MISO      = miso_q;
    assign frame_err = ferr_q;

endmodule
